// File: rtl/tlut_pkg.sv
// Shared types and helpers for the handshaked temporal-LUT SIMD multiply cell.
package tlut_pkg;

  // Upper bounds for the generic max_input reduction.
  localparam int unsigned MaxLanes = 32;
  localparam int unsigned MaxIw    = 32;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic int unsigned acc_width(input int unsigned iw, input int unsigned ww);
    return iw + ww;
  endfunction

  // Maximum of `lanes` packed unsigned fields of width `iw` held in the low bits of v.
  function automatic logic [MaxIw-1:0] max_input(input logic [MaxLanes*MaxIw-1:0] v,
                                                 input int unsigned lanes,
                                                 input int unsigned iw);
    logic [MaxIw-1:0] m;
    logic [MaxIw-1:0] lane;
    logic [MaxIw-1:0] mask;
    m    = '0;
    mask = (iw >= MaxIw) ? '1 : MaxIw'((64'(1) << iw) - 64'(1));
    for (int unsigned i = 0; i < MaxLanes; i++) begin
      lane = MaxIw'(v >> (i * iw)) & mask;
      if (i < lanes && lane > m) m = lane;
    end
    return m;
  endfunction

endpackage

// File: rtl/tlut_temporal_ctrl.sv
// Sequencer: handshake FSM, step counter and per-lane temporal enables.
module tlut_temporal_ctrl
  import tlut_pkg::*;
#(
  parameter int unsigned DIM_A       = 4,
  parameter int unsigned INPUT_WIDTH = 8,
  parameter bit          EARLY_TERM  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           out_ready,
  input  logic [DIM_A*INPUT_WIDTH-1:0]   input_bin,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           acc_en,
  output logic                           clear,
  output logic [DIM_A-1:0]               lane_en
);

  state_e                         state_q;
  logic [INPUT_WIDTH-1:0]         t_q;
  logic [INPUT_WIDTH-1:0]         n_q;
  logic [DIM_A*INPUT_WIDTH-1:0]   in_q;
  logic [MaxLanes*MaxIw-1:0]      in_pad;
  logic [MaxIw-1:0]               max_in;
  logic [INPUT_WIDTH-1:0]         n_next;
  logic                           accept;

  always_comb begin
    in_pad = '0;
    in_pad[DIM_A*INPUT_WIDTH-1:0] = input_bin;
    max_in = max_input(in_pad, DIM_A, INPUT_WIDTH);
    if (EARLY_TERM) begin
      // An all-zero vector still takes one step so out_valid has a defined latency.
      n_next = (max_in == '0) ? INPUT_WIDTH'(1) : max_in[INPUT_WIDTH-1:0];
    end else begin
      n_next = '1;
    end
  end

  assign in_ready  = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun);
  assign acc_en    = (state_q == StRun);
  assign clear     = accept;

  always_comb begin
    lane_en = '0;
    for (int i = 0; i < DIM_A; i++) begin
      lane_en[i] = (state_q == StRun) && (t_q < in_q[i*INPUT_WIDTH +: INPUT_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= '0;
      n_q     <= '0;
      in_q    <= '0;
    end else if (accept) begin
      state_q <= StRun;
      t_q     <= '0;
      n_q     <= n_next;
      in_q    <= input_bin;
    end else begin
      case (state_q)
        StRun: begin
          if (t_q == n_q - INPUT_WIDTH'(1)) begin
            state_q <= StDone;
            t_q     <= '0;
          end else begin
            t_q <= t_q + INPUT_WIDTH'(1);
          end
        end
        StDone:  if (out_ready) state_q <= StIdle;
        StIdle:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/tlut_simd_cell_hs.sv
// Handshaked temporal-LUT SIMD cell: weight accumulators plus a DIM_C x DIM_A product array.
module tlut_simd_cell_hs
  import tlut_pkg::*;
#(
  parameter int unsigned  DIM_A        = 4,
  parameter int unsigned  DIM_C        = 4,
  parameter int unsigned  INPUT_WIDTH  = 8,
  parameter int unsigned  WEIGHT_WIDTH = 8,
  parameter bit           SIGNED_W     = 1'b0,
  parameter bit           EARLY_TERM   = 1'b1,
  localparam int unsigned ACC_WIDTH    = acc_width(INPUT_WIDTH, WEIGHT_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DIM_A*INPUT_WIDTH-1:0]         input_bin,
  input  logic [DIM_C*WEIGHT_WIDTH-1:0]        weight_bin,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DIM_C*DIM_A*ACC_WIDTH-1:0]     product,
  output logic                                 busy
);

  logic                          acc_en;
  logic                          clear;
  logic [DIM_A-1:0]              lane_en;
  logic [DIM_C*WEIGHT_WIDTH-1:0] w_q;
  logic [ACC_WIDTH-1:0]          acc_q    [DIM_C];
  logic [ACC_WIDTH-1:0]          acc_nxt  [DIM_C];
  logic [ACC_WIDTH-1:0]          prod_q   [DIM_C][DIM_A];

  tlut_temporal_ctrl #(
    .DIM_A       (DIM_A),
    .INPUT_WIDTH (INPUT_WIDTH),
    .EARLY_TERM  (EARLY_TERM)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .input_bin (input_bin),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .acc_en    (acc_en),
    .clear     (clear),
    .lane_en   (lane_en)
  );

  always_comb begin
    for (int j = 0; j < DIM_C; j++) begin
      logic [WEIGHT_WIDTH-1:0] wj;
      wj         = w_q[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      acc_nxt[j] = acc_q[j] +
                   {{(ACC_WIDTH-WEIGHT_WIDTH){SIGNED_W & wj[WEIGHT_WIDTH-1]}}, wj};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q <= '0;
      for (int j = 0; j < DIM_C; j++) begin
        acc_q[j] <= '0;
        for (int i = 0; i < DIM_A; i++) prod_q[j][i] <= '0;
      end
    end else if (clear) begin
      w_q <= weight_bin;
      for (int j = 0; j < DIM_C; j++) begin
        acc_q[j] <= '0;
        for (int i = 0; i < DIM_A; i++) prod_q[j][i] <= '0;
      end
    end else if (acc_en) begin
      // Each lane freezes once its temporal bit drops, leaving w[j]*in[i].
      for (int j = 0; j < DIM_C; j++) begin
        acc_q[j] <= acc_nxt[j];
        for (int i = 0; i < DIM_A; i++) begin
          if (lane_en[i]) prod_q[j][i] <= acc_nxt[j];
        end
      end
    end
  end

  always_comb begin
    product = '0;
    for (int j = 0; j < DIM_C; j++) begin
      for (int i = 0; i < DIM_A; i++) begin
        product[(j*DIM_A+i)*ACC_WIDTH +: ACC_WIDTH] = prod_q[j][i];
      end
    end
  end

endmodule

// File: tb/tb_tlut_simd_cell_hs.sv
// Directed scoreboard bench: three 2x2, 4-bit cells (unsigned, signed, full-run) on shared stimulus.
module tb_tlut_simd_cell_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  input_bin;
  logic [7:0]  weight_bin;

  logic        rdy_u, rdy_s, rdy_f;
  logic        ov_u, ov_s, ov_f;
  logic        bsy_u, bsy_s, bsy_f;
  logic [31:0] prod_u, prod_s, prod_f;

  logic        t_rdy, t_ov, t_busy;
  logic [31:0] t_prod;
  int          sel;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  tlut_simd_cell_hs #(
    .DIM_A(2), .DIM_C(2), .INPUT_WIDTH(4), .WEIGHT_WIDTH(4), .SIGNED_W(1'b0), .EARLY_TERM(1'b1)
  ) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u), .input_bin(input_bin),
    .weight_bin(weight_bin), .out_valid(ov_u), .out_ready(out_ready), .product(prod_u),
    .busy(bsy_u)
  );

  tlut_simd_cell_hs #(
    .DIM_A(2), .DIM_C(2), .INPUT_WIDTH(4), .WEIGHT_WIDTH(4), .SIGNED_W(1'b1), .EARLY_TERM(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .input_bin(input_bin),
    .weight_bin(weight_bin), .out_valid(ov_s), .out_ready(out_ready), .product(prod_s),
    .busy(bsy_s)
  );

  tlut_simd_cell_hs #(
    .DIM_A(2), .DIM_C(2), .INPUT_WIDTH(4), .WEIGHT_WIDTH(4), .SIGNED_W(1'b0), .EARLY_TERM(1'b0)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_f), .input_bin(input_bin),
    .weight_bin(weight_bin), .out_valid(ov_f), .out_ready(out_ready), .product(prod_f),
    .busy(bsy_f)
  );

  always_comb begin
    t_rdy  = rdy_u;
    t_ov   = ov_u;
    t_busy = bsy_u;
    t_prod = prod_u;
    if (sel == 1) begin
      t_rdy = rdy_s; t_ov = ov_s; t_busy = bsy_s; t_prod = prod_s;
    end else if (sel == 2) begin
      t_rdy = rdy_f; t_ov = ov_f; t_busy = bsy_f; t_prod = prod_f;
    end
  end

  function automatic logic [31:0] model(input logic [3:0] a0, input logic [3:0] a1,
                                        input logic [3:0] w0, input logic [3:0] w1,
                                        input bit sgn);
    logic [3:0]  a[2];
    logic [3:0]  w[2];
    logic [31:0] r;
    int          wv;
    a[0] = a0; a[1] = a1; w[0] = w0; w[1] = w1;
    r = '0;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 2; i++) begin
        wv = sgn ? int'($signed(w[j])) : int'(w[j]);
        r[(j*2+i)*8 +: 8] = 8'(wv * int'(a[i]));
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
  endtask

  // Drive a vector, push its expected products, and return just after the accept edge.
  task automatic send(input logic [3:0] a0, input logic [3:0] a1,
                      input logic [3:0] w0, input logic [3:0] w1, input bit sgn);
    int cnt;
    input_bin  = {a1, a0};
    weight_bin = {w1, w0};
    in_valid   = 1'b1;
    sb.push_back(model(a0, a1, w0, w1, sgn));
    cnt = 0;
    while (!t_rdy && cnt < 50) begin
      tick;
      cnt++;
    end
    chk("send_in_ready", {31'd0, t_rdy}, 32'd1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input int lat, output logic [31:0] e);
    int cnt;
    cnt = 0;
    while (!t_ov && cnt < 40) begin
      tick;
      cnt++;
    end
    chk({tag, "_latency"}, cnt, lat);
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    chk(tag, t_prod, e);
  endtask

  initial begin
    logic [31:0] e;
    sel        = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    input_bin  = '0;
    weight_bin = '0;

    tick;
    chk("rst_in_ready", {31'd0, t_rdy}, 32'd0);
    chk("rst_out_valid", {31'd0, t_ov}, 32'd0);
    chk("rst_busy", {31'd0, t_busy}, 32'd0);
    chk("rst_product", t_prod, 32'd0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", {31'd0, t_rdy}, 32'd1);

    // Basic unsigned multiply; inputs change after accept and must be ignored.
    send(4'd3, 4'd5, 4'd2, 4'd7, 1'b0);
    input_bin  = 8'hFF;
    weight_bin = 8'hFF;
    chk("t1_busy", {31'd0, t_busy}, 32'd1);
    recv("t1", 5, e);
    chk("t1_const", e, 32'h2315_0A06);

    // All-zero inputs terminate after one step.
    send(4'd0, 4'd0, 4'd9, 4'd9, 1'b0);
    recv("t2", 1, e);

    // Signed weights.
    sel = 1;
    rst_pulse;
    send(4'd15, 4'd1, 4'hD, 4'd7, 1'b1);
    recv("t3", 15, e);
    chk("t3_const", e, 32'h0769_FDD3);

    // Backpressure, then back-to-back accept from DONE.
    sel = 0;
    rst_pulse;
    out_ready = 1'b0;
    send(4'd3, 4'd5, 4'd2, 4'd7, 1'b0);
    recv("t4a", 5, e);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("t4_hold_product", t_prod, e);
    end
    chk("t4_hold_valid", {31'd0, t_ov}, 32'd1);
    chk("t4_hold_in_ready", {31'd0, t_rdy}, 32'd0);
    input_bin  = {4'd1, 4'd2};
    weight_bin = {4'd1, 4'd1};
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    sb.push_back(model(4'd2, 4'd1, 4'd1, 4'd1, 1'b0));
    #1;
    chk("t4_b2b_in_ready", {31'd0, t_rdy}, 32'd1);
    tick;
    in_valid = 1'b0;
    chk("t4_b2b_ov_drop", {31'd0, t_ov}, 32'd0);
    chk("t4_b2b_busy", {31'd0, t_busy}, 32'd1);
    recv("t4b", 2, e);

    // Reset at t=2 of an N=10 run aborts cleanly.
    rst_pulse;
    send(4'd10, 4'd3, 4'd1, 4'd2, 1'b0);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("t5_in_ready_low", {31'd0, t_rdy}, 32'd0);
    tick;
    rst_n = 1'b1;
    #1;
    sb.delete();
    chk("t5_busy", {31'd0, t_busy}, 32'd0);
    chk("t5_out_valid", {31'd0, t_ov}, 32'd0);
    chk("t5_product", t_prod, 32'd0);
    chk("t5_in_ready", {31'd0, t_rdy}, 32'd1);

    // Full-length run without early termination.
    sel = 2;
    rst_pulse;
    send(4'd1, 4'd2, 4'd3, 4'd3, 1'b0);
    recv("t6", 15, e);
    chk("t6_const", e, 32'h0603_0603);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlut_simd_cell_hs.md
Name: tlut_simd_cell_hs

Overview:
Parametrised, handshaked successor to the temporal-LUT SIMD multiply cell. It accepts one vector of DIM_A unsigned inputs and DIM_C weights per transaction. Each input is converted to a temporal (unary) enable stream while each weight is repeatedly accumulated. Every product register captures the running weight sum while its input's temporal bit is high, giving products w[j]*in[i] for all DIM_C x DIM_A pairs. New features: valid/ready handshakes on both sides, early termination at max(input), and signed-weight mode.

Parameters:
DIM_A, 4, number of inputs (temporal lanes)
DIM_C, 4, number of weights
INPUT_WIDTH, 8, unsigned input width
WEIGHT_WIDTH, 8, weight width
SIGNED_W, 0, 1 = weights two's-complement and sign-extended; 0 = unsigned
EARLY_TERM, 1, 1 = run max(in) cycles; 0 = always run 2^INPUT_WIDTH-1 cycles
ACC_WIDTH, INPUT_WIDTH+WEIGHT_WIDTH, product/accumulator width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  input vector valid
in_ready  out  1  cell can accept a vector
input_bin  in  DIM_A x INPUT_WIDTH  unsigned inputs
weight_bin  in  DIM_C x WEIGHT_WIDTH  weights
out_valid  out  1  products valid
out_ready  in  1  consumer accepts products
product  out  DIM_C x DIM_A x ACC_WIDTH  registered products
busy  out  1  high in RUN

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous and active-low. While rst_n=0 at a posedge:
  - state <= IDLE; counter, accumulators and products <= 0.
  - out_valid=0, busy=0, in_ready=0 (in_ready is forced low while rst_n=0).
- FSM states: IDLE, RUN, DONE.
  - in_ready = (IDLE) | (DONE & out_ready).
  - out_valid = DONE.
  - busy = RUN.
- Accept (in_valid & in_ready):
  - Latch input_bin and weight_bin.
  - Compute N = EARLY_TERM ? max(max_i in[i], 1) : 2^INPUT_WIDTH-1.
  - Clear t, acc[j] and product[j][i] to 0; go to RUN.
- RUN, one step per cycle with counter t = 0..N-1:
  - acc_next[j] = acc[j] + ext(w[j]), so acc_next[j] = w[j]*(t+1).
  - If t < in[i] (temporal bit): product[j][i] <= acc_next[j]; otherwise it holds.
  - When t == N-1: go to DONE; t <= 0.
- Result: product[j][i] = w[j]*in[i] exactly, truncated to ACC_WIDTH (no overflow possible). in[i]=0 gives 0.
- Latency: out_valid rises exactly N cycles after the accept edge.
- DONE:
  - Products held stable while out_valid & ~out_ready.
  - On out_ready, with no new in_valid: go to IDLE.
  - On out_ready with in_valid (back-to-back): accept the new vector in the same cycle and go straight to RUN. out_valid drops next cycle.
- Product visibility: products are not cleared on leaving DONE, only at accept. The consumer must qualify them with out_valid.
- Input changes: changes to input_bin/weight_bin during RUN/DONE are ignored (values were latched at accept).
- in_valid while not ready: no effect; the source must hold it (standard valid/ready; no combinational path from in_valid to in_ready).
- Signed mode (SIGNED_W=1): ext() sign-extends the weight to ACC_WIDTH; inputs stay unsigned.
- Reset mid-RUN/DONE: abort and return to the reset values above; no partial out_valid.

Decomposition:
- Package tlut_pkg:
  - Width constants and the derived ACC_WIDTH function.
  - state_e enum {IDLE, RUN, DONE}.
  - max_input function (reduction over DIM_A).
- Sub-module tlut_temporal_ctrl: FSM, step counter t, N computation, handshake outputs. It drives a per-lane temporal enable vector and an acc_en/clear pair into the datapath (weight accumulators plus product array) in the top.

Test Plan:
1. DIM_A=2, DIM_C=2, IW=WW=4, unsigned; in={3,5}, w={2,7} -> out_valid 5 cycles after accept; product[0]={6,10}, product[1]={21,35}.
2. in={0,0}, w={9,9} -> N=1; out_valid 1 cycle after accept; all products 0.
3. SIGNED_W=1; in={15,1}, w={4'hD(-3), 4'h7} -> product[0]={8'hD3(-45), 8'hFD(-3)}, product[1]={105, 7}.
4. Backpressure then back-to-back:
   - Hold out_ready=0 for 10 cycles in DONE -> products stable, in_ready=0.
   - Assert out_ready with in_valid holding {2,1}, w={1,1} -> same-cycle accept; out_valid=0 next cycle; new results {2,1} after 2 cycles.
5. Assert rst_n=0 for one cycle at t=2 of an N=10 run -> next cycle: state IDLE, products 0, out_valid=0, in_ready=1 once rst_n=1.
6. EARLY_TERM=0, IW=4; in={1,2}, w={3,3} -> out_valid exactly 15 cycles after accept; products {3,6} for both rows.
